// File: rtl/icache_intc_bank_port.sv
// icache_intc_bank_port
// Per-bank port between the icache interconnect arbitration stage and one
// cache bank. Buffers granted requests in a small FIFO and issues them to the
// bank. It records the issued UIDs in order so each in-order bank read
// response returns as a registered pulse tagged with its requester's UID.
// The number of issued-but-unanswered bank transactions is bounded.
module icache_intc_bank_port #(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned UID_WIDTH       = 17,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned REQ_DEPTH       = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 request_i,
  input  logic [ADDRESS_WIDTH-1:0]             address_i,
  input  logic [UID_WIDTH-1:0]                 UID_i,
  output logic                                 grant_o,
  output logic                                 response_o,
  output logic [UID_WIDTH-1:0]                 response_UID_o,
  output logic [DATA_WIDTH-1:0]                response_data_o,
  output logic                                 bank_req_o,
  output logic [ADDRESS_WIDTH-1:0]             bank_addr_o,
  input  logic                                 bank_gnt_i,
  input  logic                                 bank_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                bank_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 error_o
);

  localparam int unsigned REQ_PW = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int unsigned REQ_CW = $clog2(REQ_DEPTH + 1);
  localparam int unsigned UID_PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [UID_WIDTH-1:0]     uid;
  } req_t;

  // Request FIFO state
  req_t              req_mem [REQ_DEPTH];
  logic [REQ_PW-1:0] req_wr_ptr, req_rd_ptr;
  logic [REQ_CW-1:0] req_count;

  // UID FIFO state; its occupancy is the outstanding count itself
  logic [UID_WIDTH-1:0] uid_mem [MAX_OUTSTANDING];
  logic [UID_PW-1:0]    uid_wr_ptr, uid_rd_ptr;
  logic [OUT_W-1:0]     outstanding, out_next;

  logic req_full, req_empty, push, issue, retire, spurious;

  function automatic logic [REQ_PW-1:0] req_ptr_next(input logic [REQ_PW-1:0] p);
    return (p == REQ_PW'(REQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [UID_PW-1:0] uid_ptr_next(input logic [UID_PW-1:0] p);
    return (p == UID_PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_full  = (req_count == REQ_CW'(REQ_DEPTH));
  assign req_empty = (req_count == '0);

  // grant depends only on registered occupancy: a same-cycle pop never opens it
  assign grant_o     = !req_full;
  assign push        = request_i & grant_o;
  assign bank_req_o  = !req_empty & (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign bank_addr_o = req_mem[req_rd_ptr].addr;
  assign issue       = bank_req_o & bank_gnt_i;
  assign retire      = bank_rvalid_i & (outstanding != '0);
  assign spurious    = bank_rvalid_i & (outstanding == '0);

  assign outstanding_o = outstanding;

  // Request FIFO payload storage
  always_ff @(posedge clk_i) begin
    // NOTE: storage arrays have no reset; the occupancy counts guard every read.
    if (push) req_mem[req_wr_ptr] <= '{addr: address_i, uid: UID_i};
  end

  // Request FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      req_wr_ptr <= '0;
      req_rd_ptr <= '0;
      req_count  <= '0;
    end else begin
      if (push)  req_wr_ptr <= req_ptr_next(req_wr_ptr);
      if (issue) req_rd_ptr <= req_ptr_next(req_rd_ptr);
      case ({push, issue})
        2'b10:   req_count <= req_count + 1'b1;
        2'b01:   req_count <= req_count - 1'b1;
        default: req_count <= req_count;
      endcase
    end
  end

  // UID FIFO payload storage, written with the UID of each issued request
  always_ff @(posedge clk_i) begin
    if (issue) uid_mem[uid_wr_ptr] <= req_mem[req_rd_ptr].uid;
  end

  // Outstanding count moves only when exactly one of issue/retire happens
  always_comb begin
    // NOTE: default assigned first so every path drives it and no latch forms.
    out_next = outstanding;
    case ({issue, retire})
      2'b10:   out_next = outstanding + 1'b1;
      2'b01:   out_next = outstanding - 1'b1;
      default: out_next = outstanding;
    endcase
  end

  // UID FIFO pointers and outstanding counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      uid_wr_ptr  <= '0;
      uid_rd_ptr  <= '0;
      outstanding <= '0;
    end else begin
      if (issue)  uid_wr_ptr <= uid_ptr_next(uid_wr_ptr);
      if (retire) uid_rd_ptr <= uid_ptr_next(uid_rd_ptr);
      outstanding <= out_next;
    end
  end

  // Registered response: one-cycle pulse, UID/data hold between pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      response_o      <= 1'b0;
      response_UID_o  <= '0;
      response_data_o <= '0;
    end else begin
      response_o <= retire;
      if (retire) begin
        response_UID_o  <= uid_mem[uid_rd_ptr];
        response_data_o <= bank_rdata_i;
      end
    end
  end

  // Sticky flag for a bank response that has no issued request to match
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       error_o <= 1'b0;
    else if (spurious) error_o <= 1'b1;
  end

endmodule

// File: tb/tb_icache_intc_bank_port.sv
// Testbench for icache_intc_bank_port: directed steps plus a queue-based
// reference model that predicts grant, issue, outstanding, error and the
// UID/data of every response.
module tb_icache_intc_bank_port;

  localparam int AW   = 32;
  localparam int UW   = 17;
  localparam int DW   = 32;
  localparam int REQD = 2;
  localparam int MAXO = 4;
  localparam int OW   = $clog2(MAXO + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          request_i = 1'b0;
  logic [AW-1:0] address_i = '0;
  logic [UW-1:0] UID_i = '0;
  logic          grant_o;
  logic          response_o;
  logic [UW-1:0] response_UID_o;
  logic [DW-1:0] response_data_o;
  logic          bank_req_o;
  logic [AW-1:0] bank_addr_o;
  logic          bank_gnt_i = 1'b0;
  logic          bank_rvalid_i = 1'b0;
  logic [DW-1:0] bank_rdata_i = '0;
  logic [OW-1:0] outstanding_o;
  logic          error_o;

  icache_intc_bank_port #(
    .ADDRESS_WIDTH(AW), .UID_WIDTH(UW), .DATA_WIDTH(DW),
    .REQ_DEPTH(REQD), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .request_i(request_i), .address_i(address_i), .UID_i(UID_i),
    .grant_o(grant_o),
    .response_o(response_o), .response_UID_o(response_UID_o),
    .response_data_o(response_data_o),
    .bank_req_o(bank_req_o), .bank_addr_o(bank_addr_o),
    .bank_gnt_i(bank_gnt_i), .bank_rvalid_i(bank_rvalid_i),
    .bank_rdata_i(bank_rdata_i),
    .outstanding_o(outstanding_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [AW-1:0] addr; logic [UW-1:0] uid; } req_m_t;
  typedef struct packed { logic [UW-1:0] uid; logic [DW-1:0] data; } rsp_m_t;

  req_m_t        req_q[$];
  logic [UW-1:0] out_q[$];
  rsp_m_t        exp_q[$];
  logic          err_model = 1'b0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compare DUT against the model just before the edge, then advance the model
  task automatic monitor();
    logic          exp_req, do_push, do_issue, do_ret;
    rsp_m_t        e;
    req_m_t        r;
    logic [UW-1:0] u;
    if (!rst_ni) begin
      req_q.delete(); out_q.delete(); exp_q.delete(); err_model = 1'b0;
      check("rst_grant", grant_o, 1);
      check("rst_bank_req", bank_req_o, 0);
      check("rst_outstanding", outstanding_o, 0);
      check("rst_error", error_o, 0);
      check("rst_response", response_o, 0);
      return;
    end
    exp_req = (req_q.size() != 0) && (out_q.size() < MAXO);
    check("grant", grant_o, req_q.size() < REQD);
    check("bank_req", bank_req_o, exp_req);
    if (exp_req) check("bank_addr", bank_addr_o, req_q[0].addr);
    check("outstanding", outstanding_o, out_q.size());
    check("error", error_o, err_model);
    check("response_valid", response_o, exp_q.size() != 0);
    if (response_o && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("response_uid", response_UID_o, e.uid);
      check("response_data", response_data_o, e.data);
    end
    do_push  = request_i && (req_q.size() < REQD);
    do_issue = exp_req && bank_gnt_i;
    do_ret   = bank_rvalid_i && (out_q.size() != 0);
    if (bank_rvalid_i && out_q.size() == 0) err_model = 1'b1;
    if (do_ret) begin
      u = out_q.pop_front();
      exp_q.push_back('{uid: u, data: bank_rdata_i});
    end
    if (do_issue) begin
      r = req_q.pop_front();
      out_q.push_back(r.uid);
    end
    if (do_push) req_q.push_back('{addr: address_i, uid: UID_i});
  endtask

  // One cycle: model check at negedge, return 1 time unit after the next posedge
  task automatic tick();
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    #1;
  endtask

  // Return every outstanding request with random data, bounded
  task automatic drain();
    int n;
    n = 0;
    request_i = 1'b0;
    bank_gnt_i = 1'b1;
    while ((outstanding_o != 0 || bank_req_o) && n < 40) begin
      bank_rvalid_i = (outstanding_o != 0);
      bank_rdata_i = $urandom;
      tick();
      n++;
    end
    bank_rvalid_i = 1'b0;
    tick();
    check("drain_timeout", n < 40, 1);
  endtask

  initial begin
    int grants;

    // ---------------- reset values
    tick(); tick();
    check("reset_response_uid", response_UID_o, 0);
    check("reset_response_data", response_data_o, 0);
    check("reset_grant", grant_o, 1);
    rst_ni = 1'b1;

    // ---------------- single request, 3-cycle round trip
    request_i = 1'b1; address_i = 32'h0000_1040; UID_i = 17'h00008; bank_gnt_i = 1'b1;
    tick();
    request_i = 1'b0;
    check("single_bank_req", bank_req_o, 1);
    check("single_bank_addr", bank_addr_o, 32'h0000_1040);
    tick();
    bank_rvalid_i = 1'b1; bank_rdata_i = 32'hDEAD_BEEF;
    check("single_outstanding", outstanding_o, 1);
    tick();
    bank_rvalid_i = 1'b0;
    check("single_response", response_o, 1);
    check("single_response_uid", response_UID_o, 17'h00008);
    check("single_response_data", response_data_o, 32'hDEAD_BEEF);
    tick();
    check("single_pulse_end", response_o, 0);
    check("single_uid_hold", response_UID_o, 17'h00008);
    check("single_data_hold", response_data_o, 32'hDEAD_BEEF);

    // ---------------- backpressure: bank refuses, FIFO fills
    bank_gnt_i = 1'b0;
    request_i = 1'b1;
    grants = 0;
    for (int i = 0; i < 4; i++) begin
      address_i = 32'h2000 + 32'(i * 4);
      UID_i = 17'(1 << i);
      grants += int'(grant_o);
      tick();
    end
    check("bp_grant_count", grants, 2);
    check("bp_grant_low", grant_o, 0);
    bank_gnt_i = 1'b1;
    address_i = 32'h2100; UID_i = 17'h00100;
    check("bp_no_passthrough", grant_o, 0);
    tick();
    check("bp_grant_restored", grant_o, 1);
    tick();
    request_i = 1'b0;
    drain();

    // ---------------- outstanding limit
    bank_gnt_i = 1'b1;
    request_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      address_i = 32'h3000 + 32'(i * 4);
      UID_i = 17'(1 << (i + 4));
      tick();
    end
    request_i = 1'b0;
    check("lim_outstanding_max", outstanding_o, 4);
    check("lim_bank_req_blocked", bank_req_o, 0);
    bank_rvalid_i = 1'b1; bank_rdata_i = 32'h1111_2222;
    tick();
    bank_rvalid_i = 1'b0;
    check("lim_outstanding_3", outstanding_o, 3);
    check("lim_bank_req_again", bank_req_o, 1);
    drain();

    // ---------------- ordering of UID/data pairs
    bank_gnt_i = 1'b1;
    request_i = 1'b1;
    address_i = 32'h0100; UID_i = 17'h00001; tick();
    address_i = 32'h0104; UID_i = 17'h00004; tick();
    address_i = 32'h0108; UID_i = 17'h00010; tick();
    request_i = 1'b0;
    tick();
    check("ord_outstanding", outstanding_o, 3);
    bank_rvalid_i = 1'b1; bank_rdata_i = 32'hAAAA_0001; tick();
    bank_rdata_i = 32'hBBBB_0002;
    check("ord_uid_0", response_UID_o, 17'h00001);
    check("ord_data_0", response_data_o, 32'hAAAA_0001);
    tick();
    bank_rdata_i = 32'hCCCC_0003;
    check("ord_uid_1", response_UID_o, 17'h00004);
    check("ord_data_1", response_data_o, 32'hBBBB_0002);
    tick();
    bank_rvalid_i = 1'b0;
    check("ord_uid_2", response_UID_o, 17'h00010);
    check("ord_data_2", response_data_o, 32'hCCCC_0003);
    tick();
    check("ord_outstanding_0", outstanding_o, 0);

    // ---------------- simultaneous issue and rvalid at outstanding=2
    bank_gnt_i = 1'b1;
    request_i = 1'b1;
    address_i = 32'h0400; UID_i = 17'h00002; tick();
    address_i = 32'h0404; UID_i = 17'h00020; tick();
    address_i = 32'h0408; UID_i = 17'h00040; tick();
    request_i = 1'b0; bank_gnt_i = 1'b0;
    tick();
    check("sim_outstanding_before", outstanding_o, 2);
    check("sim_bank_req", bank_req_o, 1);
    bank_gnt_i = 1'b1; bank_rvalid_i = 1'b1; bank_rdata_i = 32'hD000_0001;
    tick();
    check("sim_outstanding_after", outstanding_o, 2);
    check("sim_uid_0", response_UID_o, 17'h00002);
    bank_rdata_i = 32'hD000_0002;
    tick();
    check("sim_uid_1", response_UID_o, 17'h00020);
    bank_rdata_i = 32'hD000_0003;
    tick();
    bank_rvalid_i = 1'b0;
    check("sim_uid_2", response_UID_o, 17'h00040);
    check("sim_data_2", response_data_o, 32'hD000_0003);
    tick();

    // ---------------- spurious rvalid
    check("spur_outstanding_pre", outstanding_o, 0);
    bank_rvalid_i = 1'b1; bank_rdata_i = 32'h5555_5555;
    tick();
    bank_rvalid_i = 1'b0;
    check("spur_error", error_o, 1);
    check("spur_no_response", response_o, 0);
    check("spur_outstanding", outstanding_o, 0);
    tick(); tick();
    check("spur_error_sticky", error_o, 1);

    // ---------------- async reset mid-traffic
    bank_gnt_i = 1'b1;
    request_i = 1'b1;
    address_i = 32'h0800; UID_i = 17'h00080; tick();
    address_i = 32'h0804; UID_i = 17'h00100; tick();
    address_i = 32'h0808; UID_i = 17'h00200; tick();
    check("mid_outstanding_nonzero", outstanding_o != 0, 1);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_grant", grant_o, 1);
    check("mid_rst_bank_req", bank_req_o, 0);
    check("mid_rst_outstanding", outstanding_o, 0);
    check("mid_rst_error", error_o, 0);
    tick();
    request_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    check("post_rst_grant", grant_o, 1);
    check("post_rst_bank_req", bank_req_o, 0);
    bank_rvalid_i = 1'b1; bank_rdata_i = 32'h7777_0000;
    tick();
    bank_rvalid_i = 1'b0;
    check("post_rst_stale_error", error_o, 1);
    check("post_rst_no_response", response_o, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_intc_bank_port.md
# icache_intc_bank_port

Per-bank request/response port between the instruction-cache interconnect's routing/arbitration stage and one cache bank. Accepts arbitrated requests (address + one-hot UID) on a req/grant handshake, buffers them in a small request FIFO, and issues them to the bank. It tracks issued UIDs in order and returns each bank read response as a registered response pulse tagged with the originating UID, bounding the number of outstanding bank transactions.

## Interface
- ADDRESS_WIDTH, 32, request address width
- UID_WIDTH, 17, one-hot requester ID width (cores + aux channels)
- DATA_WIDTH, 32, bank read data width
- REQ_DEPTH, 2, request FIFO entries (>=1)
- MAX_OUTSTANDING, 4, max issued-but-unanswered bank requests (>=1)

Ports. Reset rst_ni is asynchronous, active-low; clock is clk_i.
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- request_i  in  1  arbitrated request valid from routing stage
- address_i  in  ADDRESS_WIDTH  request address
- UID_i  in  UID_WIDTH  one-hot requester ID
- grant_o  out  1  request accepted this cycle when request_i=1
- response_o  out  1  response valid pulse toward routing stage
- response_UID_o  out  UID_WIDTH  UID of the returning response
- response_data_o  out  DATA_WIDTH  read data of the returning response
- bank_req_o  out  1  request to cache bank
- bank_addr_o  out  ADDRESS_WIDTH  bank request address
- bank_gnt_i  in  1  bank accepts bank_req_o
- bank_rvalid_i  in  1  bank read response valid, in issue order
- bank_rdata_i  in  DATA_WIDTH  bank read data
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count
- error_o  out  1  sticky protocol error

## Operation
- Request FIFO holds {address, UID}. grant_o = !req_full. It depends only on registered state and never on request_i. Push on request_i & grant_o. No pass-through when full: a pop in the same cycle does not raise grant_o.
- Issue: bank_req_o = !req_empty & (outstanding < MAX_OUTSTANDING). bank_addr_o = head address. Pop on bank_req_o & bank_gnt_i. The popped UID is pushed into the UID FIFO (depth MAX_OUTSTANDING) and outstanding increments.
- bank_gnt_i with bank_req_o=0 is ignored.
- Response: on bank_rvalid_i with UID FIFO non-empty:
  - pop the UID;
  - register response_o=1, response_UID_o=head UID, response_data_o=bank_rdata_i;
  - decrement outstanding.
- response_o is a one-cycle pulse per rvalid. response_UID_o and response_data_o hold their last values while response_o=0.
- Simultaneous issue and rvalid in the same cycle: outstanding unchanged, both FIFO operations performed.
- bank_rvalid_i with the UID FIFO empty is a protocol violation:
  - set error_o (sticky until reset);
  - no response_o pulse;
  - outstanding stays 0 (no underflow).
- outstanding never exceeds MAX_OUTSTANDING by construction. Counter width is $clog2(MAX_OUTSTANDING+1).
- FIFO pointers wrap modulo depth. Full/empty are derived from an occupancy count, so non-power-of-2 depths are legal.

## Timing
- Reset values:
  - bank_req_o=0, response_o=0, response_UID_o=0, response_data_o=0;
  - outstanding_o=0, error_o=0;
  - grant_o=1 (FIFOs empty).
- Request accepted in cycle N gives bank_req_o=1 at N+1 at the earliest. There is no same-cycle bypass.
- bank_rvalid_i in cycle M gives response_o=1 in cycle M+1.
- Minimum round trip, request_i to response_o: 3 cycles with single-cycle bank grant and rvalid one cycle after grant.
- Sustained throughput: 1 request/cycle when REQ_DEPTH>=2, bank_gnt_i stays high, and responses keep outstanding below the limit.
- Reset mid-operation clears both FIFOs, outstanding and error_o immediately (async). Bank responses arriving after reset for pre-reset requests set error_o.

## Test plan
- Single request: address 0x0000_1040, UID bit 3, bank_gnt_i=1, rvalid next cycle with data 0xDEADBEEF:
  - bank_req_o at cycle 1 with bank_addr_o=0x1040;
  - response_o at cycle 3 with response_UID_o=0x00008, response_data_o=0xDEADBEEF.
- Backpressure: bank_gnt_i=0, request_i held high with REQ_DEPTH=2:
  - exactly 2 grants, then grant_o=0;
  - releasing bank_gnt_i restores grant_o one cycle after the first pop.
- Outstanding limit: MAX_OUTSTANDING=4, bank always grants, rvalid withheld:
  - 4 issues, then bank_req_o=0 with outstanding_o=4;
  - one rvalid brings outstanding_o to 3 and re-enables bank_req_o the next cycle.
- Ordering: issue UIDs 0x1, 0x4, 0x10; return 3 rvalids with data A, B, C:
  - responses carry UID/data pairs (0x1,A), (0x4,B), (0x10,C) in that order.
- Simultaneous issue+rvalid at outstanding=2: outstanding_o stays 2 and the UID FIFO order is preserved.
- Spurious rvalid at outstanding=0: error_o=1 and stays 1, no response_o, outstanding_o=0. Async reset mid-traffic clears everything, with grant_o=1 and bank_req_o=0 during and after reset.
